// File: rtl/clock_div_1hz_pkg.sv
// Helpers shared by the divider and its counter. They turn clock
// frequencies into half-period lengths and counter widths.
`timescale 1ns/1ps
package clock_div_1hz_pkg;

  // clk_in cycles per clk_out half-period.
  // The division truncates; a zero output rate gives 0.
  function automatic int calc_half_cnt(input int clk_in_hz, input int clk_out_hz);
    if (clk_out_hz == 0) return 0;
    return clk_in_hz / (2 * clk_out_hz);
  endfunction

  // Width needed to count 0..half_cnt-1, never narrower than one bit.
  function automatic int calc_cnt_w(input int half_cnt);
    if (half_cnt <= 2) return 1;
    return $clog2(half_cnt);
  endfunction

endpackage

// File: rtl/clock_div_1hz_if.sv
// Output bundle of the divider: the slow square wave plus its rise strobe.
`timescale 1ns/1ps
interface clock_div_1hz_if;
  logic clk_out;
  logic tick;

  modport master (output clk_out, output tick);
  modport slave  (input  clk_out, input  tick);
endinterface

// File: rtl/clock_div_1hz_mod_counter.sv
// Wrap-around counter. It counts 0..MOD-1 and flags the last count so the
// owner can act on the cycle where the count folds back to zero.
`timescale 1ns/1ps
module mod_counter
  import clock_div_1hz_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = calc_cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  // The zero initial value holds at power-up even if reset is never pulsed.
  logic [W-1:0] cnt_reg = '0;

  // Advance every cycle and fold back to zero after the last count.
  // With MOD == 1 the count stays at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign wrap = (cnt_reg == LAST);

endmodule

// File: rtl/clock_div_1hz.sv
// 50 % duty-cycle clock divider. It also emits a one-cycle tick in the
// clk_in domain on each clk_out rising edge. clk_out is meant for slow
// fabric logic such as LED blinkers, not for use as a global clock.
`timescale 1ns/1ps
module clock_div_1hz
  import clock_div_1hz_pkg::*;
#(
  parameter int CLK_IN_HZ  = 100_000_000,
  parameter int CLK_OUT_HZ = 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  clock_div_1hz_if.master         out_if
);

  localparam int HALF_CNT = calc_half_cnt(CLK_IN_HZ, CLK_OUT_HZ);
  localparam int CNT_W    = calc_cnt_w(HALF_CNT);
  // Keeps the counter well formed so the ratio error below is the only message.
  localparam int MOD      = (HALF_CNT < 1) ? 1 : HALF_CNT;

  // A ratio below 2 cannot produce a square wave at all.
  if (CLK_OUT_HZ == 0 || CLK_IN_HZ < 2 * CLK_OUT_HZ) begin : g_bad_ratio
    $error("clock_div_1hz: CLK_IN_HZ must be at least 2*CLK_OUT_HZ and CLK_OUT_HZ nonzero");
  end

  logic [CNT_W-1:0] cnt_unused;
  logic             wrap;

  mod_counter #(
    .MOD (MOD),
    .W   (CNT_W)
  ) u_half_counter (
    .clk   (clk_in),
    .reset (reset),
    .cnt   (cnt_unused),
    .wrap  (wrap)
  );

  // Zero initial values hold at power-up, so clk_out never reads X.
  logic clk_out_reg = 1'b0;
  logic tick_reg    = 1'b0;

  // Toggle on each half-period wrap. Tick fires only on the 0->1 toggle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else if (wrap) begin
      clk_out_reg <= ~clk_out_reg;
      tick_reg    <= ~clk_out_reg;
    end else begin
      tick_reg    <= 1'b0;
    end
  end

  assign out_if.clk_out = clk_out_reg;
  assign out_if.tick    = tick_reg;

endmodule

// File: tb/tb_clock_div_1hz.sv
// Bench for clock_div_1hz. Two instances share one clk_in and one reset:
// one with a ratio of 5000 cycles per half-period, one with a ratio of 1.
// Outputs are compared at every negedge against a reference built from the
// number of clk_in edges since reset release.
`timescale 1ns/1ps
module tb_clock_div_1hz;
  import clock_div_1hz_pkg::*;

  localparam int H1 = 5000;  // 100_000 Hz / (2*10 Hz)
  localparam int H2 = 1;     // 2 Hz / (2*1 Hz)

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  clock_div_1hz_if div1 ();
  clock_div_1hz_if div2 ();

  clock_div_1hz #(.CLK_IN_HZ(100_000), .CLK_OUT_HZ(10)) u_dut1 (
    .clk_in (clk_in),
    .reset  (reset),
    .out_if (div1)
  );

  clock_div_1hz #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) u_dut2 (
    .clk_in (clk_in),
    .reset  (reset),
    .out_if (div2)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int errors   = 0;
  int tick_cnt = 0;

  // Reference: the count of rising clk_in edges since reset last released.
  int unsigned edges = 0;
  always @(posedge clk_in or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  longint rise_q[$];
  longint fall_q[$];
  always @(posedge div1.clk_out) rise_q.push_back(longint'($time));
  always @(negedge div1.clk_out) fall_q.push_back(longint'($time));

  // After e edges, clk_out has toggled floor(e/h) times.
  function automatic logic model_out(int unsigned e, int unsigned h);
    return ((e / h) % 2) == 1;
  endfunction

  // Tick follows only the edges where clk_out goes 0->1.
  function automatic logic model_tick(int unsigned e, int unsigned h);
    return (e > 0) && ((e % (2 * h)) == h);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t edges=%0d", tag, obs, exp, $time, edges);
    end
  endtask

  task automatic chk_int(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      chk("div1_clk_out", div1.clk_out, model_out(edges, H1));
      chk("div1_tick",    div1.tick,    model_tick(edges, H1));
      chk("div2_clk_out", div2.clk_out, model_out(edges, H2));
      chk("div2_tick",    div2.tick,    model_tick(edges, H2));
      if (div1.tick === 1'b1) tick_cnt++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_clk_out1"}, div1.clk_out, 1'b0);
    chk({tag, "_tick1"},    div1.tick,    1'b0);
    chk({tag, "_clk_out2"}, div2.clk_out, 1'b0);
    chk({tag, "_tick2"},    div2.tick,    1'b0);
  endtask

  initial begin
    int n;
    int half_default;
    int in_hz;
    int out_hz;

    // Derived constants for the default 100 MHz -> 1 Hz build.
    in_hz  = 100_000_000;
    out_hz = 1;
    half_default = calc_half_cnt(in_hz, out_hz);
    chk_int("half_cnt_default", half_default, 50_000_000);
    chk_int("cnt_w_default", calc_cnt_w(half_default), 26);
    chk_int("half_cnt_1hz_in", calc_half_cnt(out_hz, out_hz), 0);

    // Reset pulse at start, then the fixed time points of the 10 Hz run.
    #1;
    chk_reset_state("in_reset");
    #1 reset = 1'b0;
    #8;
    chk("t10_clk_out", div1.clk_out, 1'b0);
    #1;
    run_cycles(5000);                    // t = 50_010
    chk("t50k_clk_out", div1.clk_out, 1'b1);
    run_cycles(5000);                    // t = 100_010
    chk("t100k_clk_out", div1.clk_out, 1'b0);
    run_cycles(5000);                    // t = 150_010
    chk("t150k_clk_out", div1.clk_out, 1'b1);
    run_cycles(5000);                    // t = 200_010
    chk_int("ticks_in_200k", tick_cnt, 2);
    run_cycles(20000);                   // t = 400_010, four full periods

    // Period, high time and low time over four periods.
    chk_int("rise_count", rise_q.size(), 4);
    chk_int("fall_count", fall_q.size(), 4);
    if (rise_q.size() >= 4 && fall_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_int($sformatf("high_time_%0d", i), fall_q[i] - rise_q[i], 50_000);
        if (i < 3) begin
          chk_int($sformatf("low_time_%0d", i), rise_q[i+1] - fall_q[i], 50_000);
          chk_int($sformatf("period_%0d", i), rise_q[i+1] - rise_q[i], 100_000);
        end
      end
      chk_int("first_rise_time", rise_q[0], 49_995);
    end

    // Asynchronous reset while clk_out is high, between clock edges.
    run_cycles(5000);                    // clk_out high again
    chk("pre_reset_high", div1.clk_out, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    #30 reset = 1'b0;                    // held three cycles, released between edges
    n = 0;
    while (n < 6000) begin
      @(posedge clk_in);
      #1;
      n++;
      if (div1.clk_out === 1'b1) break;
    end
    chk_int("edges_to_first_rise", n, H1);
    run_cycles(20);

    // Random reset pulses at random phases, then randomly long free runs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      #($urandom_range(1, 4));
      reset = 1'b1;
      #1;
      chk_reset_state($sformatf("rand_reset_%0d", k));
      repeat ($urandom_range(1, 3)) @(negedge clk_in);
      #($urandom_range(1, 4));
      reset = 1'b0;
      run_cycles($urandom_range(1, 7000));
    end
    run_cycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
